// File: rtl/sc_reg_casas_ocupadas_if.sv
// Signal bundle between the game controller and the house-occupancy register.
// The controller drives the strobes; the register returns occupancy, count and event pulses.
interface sc_reg_casas_ocupadas_if #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int POS_WIDTH     = 3
) ();
    logic                     SC_RegCASAS_clear_InHigh;
    logic                     SC_RegCASAS_arrive_InHigh;
    logic [POS_WIDTH-1:0]     SC_RegCASAS_pos_In;
    logic [DATAWIDTH_BUS-1:0] SC_RegCASAS_data_Out;
    logic [3:0]               SC_RegCASAS_count_Out;
    logic                     SC_RegCASAS_dup_OutHigh;
    logic                     SC_RegCASAS_levelDone_OutHigh;
    logic                     SC_RegCASAS_busy_OutHigh;

    modport master (
        output SC_RegCASAS_clear_InHigh,
        output SC_RegCASAS_arrive_InHigh,
        output SC_RegCASAS_pos_In,
        input  SC_RegCASAS_data_Out,
        input  SC_RegCASAS_count_Out,
        input  SC_RegCASAS_dup_OutHigh,
        input  SC_RegCASAS_levelDone_OutHigh,
        input  SC_RegCASAS_busy_OutHigh
    );

    modport slave (
        input  SC_RegCASAS_clear_InHigh,
        input  SC_RegCASAS_arrive_InHigh,
        input  SC_RegCASAS_pos_In,
        output SC_RegCASAS_data_Out,
        output SC_RegCASAS_count_Out,
        output SC_RegCASAS_dup_OutHigh,
        output SC_RegCASAS_levelDone_OutHigh,
        output SC_RegCASAS_busy_OutHigh
    );
endinterface

// File: rtl/sc_reg_casas_ocupadas.sv
// Frogger goal-house occupancy register: PLAY -> FULL -> CELEB -> CLEAR -> PLAY.
// Optional CELEB blink of the occupancy output is enabled with macro CASAS_BLINK_EN.
module sc_reg_casas_ocupadas #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int POS_WIDTH     = 3,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int BLINK_DIV     = 6_250_000
) (
    input  logic                SC_RegCASAS_CLOCK_50,
    input  logic                SC_RegCASAS_RESET_InHigh,
    sc_reg_casas_ocupadas_if.slave bus
);

    localparam int                       HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [POS_WIDTH:0]       N_HOUSES  = (POS_WIDTH + 1)'(DATAWIDTH_BUS);
    localparam logic [DATAWIDTH_BUS-1:0] ALL_ONES  = '1;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        FULL  = 2'd1,
        CELEB = 2'd2,
        CLEAR = 2'd3
    } state_t;

    generate
        if (DATAWIDTH_BUS < 2 || DATAWIDTH_BUS > 15 || DATAWIDTH_BUS > (1 << POS_WIDTH) ||
            HOLD_CYCLES < 1 || BLINK_DIV < 1) begin : g_bad_params
            $error("sc_reg_casas_ocupadas: illegal parameter combination");
        end
    endgenerate

    logic clk;
    logic rst;
    assign clk = SC_RegCASAS_CLOCK_50;
    assign rst = SC_RegCASAS_RESET_InHigh;

    state_t                   state;
    state_t                   next_state;
    logic [DATAWIDTH_BUS-1:0] occ;
    logic [3:0]               count;
    logic                     dup;
    logic                     level_done;
    logic                     busy;
    logic [HOLD_W-1:0]        hold_cnt;

    logic [DATAWIDTH_BUS-1:0] pos_mask;
    logic                     pos_valid;
    logic                     landing;
    logic                     hit_free;
    logic                     hit_taken;
    logic                     fills_level;

    // Decode the arrival; out-of-range indices never reach the occupancy vector.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pos_valid   = ({1'b0, bus.SC_RegCASAS_pos_In} < N_HOUSES);
        pos_mask    = '0;
        if (pos_valid) begin
            pos_mask[bus.SC_RegCASAS_pos_In] = 1'b1;
        end
        landing     = (state == PLAY) && bus.SC_RegCASAS_arrive_InHigh && pos_valid;
        hit_free    = landing && ((occ & pos_mask) == '0);
        hit_taken   = landing && ((occ & pos_mask) != '0);
        fills_level = hit_free && ((occ | pos_mask) == ALL_ONES);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PLAY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            PLAY:    if (fills_level) next_state = FULL;
            FULL:    next_state = CELEB;
            CELEB:   if (hold_cnt == HOLD_LAST) next_state = CLEAR;
            CLEAR:   next_state = PLAY;
            default: next_state = PLAY;
        endcase
        // Restart wins over everything, including a simultaneous landing.
        if (bus.SC_RegCASAS_clear_InHigh) begin
            next_state = PLAY;
        end
    end

    // NOTE: the occupancy vector is a handful of flops, not a memory, so it takes the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ        <= '0;
            count      <= '0;
            dup        <= 1'b0;
            level_done <= 1'b0;
            busy       <= 1'b0;
            hold_cnt   <= '0;
        end else if (bus.SC_RegCASAS_clear_InHigh) begin
            occ        <= '0;
            count      <= '0;
            dup        <= 1'b0;
            level_done <= 1'b0;
            busy       <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            dup        <= hit_taken;
            level_done <= fills_level;
            busy       <= (next_state != PLAY);
            hold_cnt   <= (state == CELEB && next_state == CELEB) ? hold_cnt + 1'b1 : '0;
            if (hit_free) begin
                occ   <= occ | pos_mask;
                count <= count + 4'd1;
            end else if (state == CLEAR) begin
                occ   <= '0;
                count <= '0;
            end
        end
    end

`ifdef CASAS_BLINK_EN
    localparam int                BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    // Phase restarts outside CELEB so every celebration opens with the lit half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (state != CELEB) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign bus.SC_RegCASAS_data_Out = (state == CELEB && !blink_on) ? '0 : occ;
`else
    assign bus.SC_RegCASAS_data_Out = occ;
`endif

    assign bus.SC_RegCASAS_count_Out         = count;
    assign bus.SC_RegCASAS_dup_OutHigh       = dup;
    assign bus.SC_RegCASAS_levelDone_OutHigh = level_done;
    assign bus.SC_RegCASAS_busy_OutHigh      = busy;

endmodule

// File: tb/tb_sc_reg_casas_ocupadas.sv
// Scoreboard bench for sc_reg_casas_ocupadas: stimulus queues expected outputs, a monitor checks them.
`timescale 1ns/1ps
module tb_sc_reg_casas_ocupadas;
    localparam int DW    = 8;
    localparam int PW    = 3;
    localparam int HOLD  = 4;
    localparam int BLINK = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sc_reg_casas_ocupadas_if #(.DATAWIDTH_BUS(DW), .POS_WIDTH(PW)) bus ();

    sc_reg_casas_ocupadas #(
        .DATAWIDTH_BUS(DW),
        .POS_WIDTH    (PW),
        .HOLD_CYCLES  (HOLD),
        .BLINK_DIV    (BLINK)
    ) dut (
        .SC_RegCASAS_CLOCK_50    (clk),
        .SC_RegCASAS_RESET_InHigh(rst),
        .bus                     (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [3:0] count;
        logic       dup;
        logic       ld;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Monitor: one expected record per clock, compared on the falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (bus.SC_RegCASAS_data_Out !== e.data || bus.SC_RegCASAS_count_Out !== e.count ||
                    bus.SC_RegCASAS_dup_OutHigh !== e.dup || bus.SC_RegCASAS_levelDone_OutHigh !== e.ld ||
                    bus.SC_RegCASAS_busy_OutHigh !== e.busy) begin
                    miscompares++;
                    $display("FAIL %s: got data=%h count=%0d dup=%b ld=%b busy=%b, expected data=%h count=%0d dup=%b ld=%b busy=%b",
                             e.name, bus.SC_RegCASAS_data_Out, bus.SC_RegCASAS_count_Out,
                             bus.SC_RegCASAS_dup_OutHigh, bus.SC_RegCASAS_levelDone_OutHigh,
                             bus.SC_RegCASAS_busy_OutHigh, e.data, e.count, e.dup, e.ld, e.busy);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected right after that edge.
    task automatic step(input string name, input logic clr, input logic arr, input logic [2:0] p,
                        input logic [7:0] d, input logic [3:0] c, input logic du, input logic ld,
                        input logic bz);
        exp_t e;
        bus.SC_RegCASAS_clear_InHigh  = clr;
        bus.SC_RegCASAS_arrive_InHigh = arr;
        bus.SC_RegCASAS_pos_In        = p;
        @(posedge clk);
        e.name  = name;
        e.data  = d;
        e.count = c;
        e.dup   = du;
        e.ld    = ld;
        e.busy  = bz;
        sb.push_back(e);
        #1;
        bus.SC_RegCASAS_clear_InHigh  = 1'b0;
        bus.SC_RegCASAS_arrive_InHigh = 1'b0;
        bus.SC_RegCASAS_pos_In        = '0;
    endtask

    // Visible data during the k-th CELEB cycle (k = 1..HOLD).
    function automatic logic [7:0] celeb_data(input int k);
`ifdef CASAS_BLINK_EN
        return (((k - 1) / BLINK) % 2 == 0) ? 8'hFF : 8'h00;
`else
        if (k < 0) return 8'h00;
        return 8'hFF;
`endif
    endfunction

    // Land on every free house in ascending order; the last landing enters FULL.
    task automatic fill_level(input logic [7:0] start, input int start_count);
        logic [7:0] d;
        int         c;
        d = start;
        c = start_count;
        for (int i = 0; i < DW; i++) begin
            if (!start[i]) begin
                d = d | (8'd1 << i);
                c++;
                step($sformatf("fill_pos%0d", i), 1'b0, 1'b1, 3'(i), d, 4'(c), 1'b0,
                     (d == 8'hFF), (d == 8'hFF));
            end
        end
    endtask

    initial begin : stimulus
        bus.SC_RegCASAS_clear_InHigh  = 1'b0;
        bus.SC_RegCASAS_arrive_InHigh = 1'b0;
        bus.SC_RegCASAS_pos_In        = '0;
        repeat (2) @(posedge clk);
        step("reset", 1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // First landing and duplicate landing.
        step("arrive3",   1'b0, 1'b1, 3'd3, 8'h08, 4'd1, 1'b0, 1'b0, 1'b0);
        step("idle0",     1'b0, 1'b0, 3'd0, 8'h08, 4'd1, 1'b0, 1'b0, 1'b0);
        step("dup3",      1'b0, 1'b1, 3'd3, 8'h08, 4'd1, 1'b1, 1'b0, 1'b0);
        step("dup_drops", 1'b0, 1'b0, 3'd0, 8'h08, 4'd1, 1'b0, 1'b0, 1'b0);

        // Level 1: fill, then FULL + 4 CELEB + CLEAR, with an arrival ignored in CELEB.
        fill_level(8'h08, 1);
        step("celeb1",       1'b0, 1'b0, 3'd0, celeb_data(1), 4'd8, 1'b0, 1'b0, 1'b1);
        step("celeb_arrive", 1'b0, 1'b1, 3'd5, celeb_data(2), 4'd8, 1'b0, 1'b0, 1'b1);
        step("celeb3",       1'b0, 1'b0, 3'd0, celeb_data(3), 4'd8, 1'b0, 1'b0, 1'b1);
        step("celeb4",       1'b0, 1'b0, 3'd0, celeb_data(4), 4'd8, 1'b0, 1'b0, 1'b1);
        step("clear_state",  1'b0, 1'b0, 3'd0, 8'hFF,         4'd8, 1'b0, 1'b0, 1'b1);
        step("next_level",   1'b0, 1'b0, 3'd0, 8'h00,         4'd0, 1'b0, 1'b0, 1'b0);

        // Clear beats a simultaneous landing, free or occupied.
        step("arrive3_again",   1'b0, 1'b1, 3'd3, 8'h08, 4'd1, 1'b0, 1'b0, 1'b0);
        step("clear_vs_arrive", 1'b1, 1'b1, 3'd2, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        step("arrive3_third",   1'b0, 1'b1, 3'd3, 8'h08, 4'd1, 1'b0, 1'b0, 1'b0);
        step("clear_vs_dup",    1'b1, 1'b1, 3'd3, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        step("idle_cleared",    1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

        // Level 2: clear during CELEB returns straight to PLAY.
        fill_level(8'h00, 0);
        step("l2_celeb1",   1'b0, 1'b0, 3'd0, celeb_data(1), 4'd8, 1'b0, 1'b0, 1'b1);
        step("clear_celeb", 1'b1, 1'b0, 3'd0, 8'h00,         4'd0, 1'b0, 1'b0, 1'b0);
        step("after_clear", 1'b0, 1'b0, 3'd0, 8'h00,         4'd0, 1'b0, 1'b0, 1'b0);

        // Level 3: short reset pulse between edges mid-CELEB must take effect on its own.
        fill_level(8'h00, 0);
        step("l3_celeb1", 1'b0, 1'b0, 3'd0, celeb_data(1), 4'd8, 1'b0, 1'b0, 1'b1);
        step("l3_celeb2", 1'b0, 1'b0, 3'd0, celeb_data(2), 4'd8, 1'b0, 1'b0, 1'b1);
        #5;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step("async_reset", 1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        step("recover1",    1'b0, 1'b1, 3'd1, 8'h02, 4'd1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected records left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
